// File: rtl/fifo_rd_stream.sv
// Read-side stage for fifo_memory: tracks how many words the memory holds,
// issues read strobes only when a word exists and the output queue has a
// reserved slot, captures the returned data and presents it as a
// valid/ready stream.
module fifo_rd_stream #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int FIFO_ADDR  = 5,
  parameter int OBUF_DEPTH = 3
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 mem_wr_en,
  output logic                 mem_rd_en,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  input  logic                 rd_empty_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [FIFO_ADDR:0]   mem_count,
  output logic                 underflow_err,
  input  logic                 clr_err
);

  localparam int QC_W = $clog2(OBUF_DEPTH + 1);
  localparam int QP_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam logic [QC_W:0]      OBUF_LIM  = (QC_W + 1)'(OBUF_DEPTH);
  localparam logic [FIFO_ADDR:0] DEPTH_CNT = (FIFO_ADDR + 1)'(FIFO_DEPTH);
  localparam logic [QP_W-1:0]    LAST_PTR  = QP_W'(OBUF_DEPTH - 1);

  logic              inflight;
  logic [QC_W-1:0]   q_cnt;
  logic [QP_W-1:0]   head;
  logic [QP_W-1:0]   tail;
  logic [WIDTH-1:0]  queue [OBUF_DEPTH];
  logic [QC_W:0]     credit_used;
  logic              wr_acc;
  logic              push;
  logic              pop;

  function automatic logic [QP_W-1:0] next_ptr(input logic [QP_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Read credit counts both queued words and the word still in flight, so a
  // returning word always has a free slot; none of this depends on out_ready.
  always_comb begin
    credit_used = {1'b0, q_cnt} + {{QC_W{1'b0}}, inflight};
    mem_rd_en   = (mem_count != '0) && (credit_used < OBUF_LIM);
    wr_acc      = mem_wr_en && ((mem_count < DEPTH_CNT) || mem_rd_en);
    push        = inflight;
    out_valid   = (q_cnt != '0);
    pop         = out_valid && out_ready;
    out_data    = queue[head];
  end

  // Memory occupancy: a write into a full memory only lands if a read frees a slot.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_count <= '0;
    end else begin
      case ({wr_acc, mem_rd_en})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
    end
  end

  // Remember that fifo_rd_data will carry a fresh word next cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      inflight <= 1'b0;
    end else begin
      inflight <= mem_rd_en;
    end
  end

  // Output queue: capture at tail when a read returns, release head on handshake.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      q_cnt <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        queue[i] <= '0;
      end
    end else begin
      if (push) begin
        queue[tail] <= fifo_rd_data;
        tail        <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      if (push && !pop) begin
        q_cnt <= q_cnt + 1'b1;
      end else if (!push && pop) begin
        q_cnt <= q_cnt - 1'b1;
      end
    end
  end

  // Sticky empty-read flag; a clear request beats a same-cycle report.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      underflow_err <= 1'b0;
    end else if (clr_err) begin
      underflow_err <= 1'b0;
    end else if (rd_empty_err) begin
      underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural fifo_memory beside it.
module tb_fifo_rd_stream;

  localparam int WIDTH      = 32;
  localparam int FIFO_DEPTH = 32;
  localparam int FIFO_ADDR  = 5;
  localparam int OBUF_DEPTH = 3;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             mem_wr_en = 1'b0;
  logic             out_ready = 1'b0;
  logic             clr_err = 1'b0;
  logic             force_err = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             mem_rd_en;
  logic             out_valid;
  logic             underflow_err;
  logic [WIDTH-1:0] fifo_rd_data;
  logic [WIDTH-1:0] out_data;
  logic [FIFO_ADDR:0] mem_count;
  logic             rd_empty_err;
  logic             model_err;

  logic [WIDTH-1:0] model_mem [FIFO_DEPTH];
  int               model_wp;
  int               model_rp;
  int               model_cnt;

  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  int               rd_pulses = 0;
  int               bad_reads = 0;
  int               first_cyc = 0;
  int               last_cyc = 0;
  logic [WIDTH-1:0] rxq [$];

  fifo_rd_stream #(
    .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .FIFO_ADDR(FIFO_ADDR), .OBUF_DEPTH(OBUF_DEPTH)
  ) dut (
    .CLK(CLK), .nRST(nRST), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .fifo_rd_data(fifo_rd_data), .rd_empty_err(rd_empty_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_count(mem_count), .underflow_err(underflow_err), .clr_err(clr_err)
  );

  always #5 CLK = ~CLK;

  assign rd_empty_err = model_err | force_err;

  // Behavioural fifo_memory: registered read data, flags a read while empty.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      model_wp     <= 0;
      model_rp     <= 0;
      model_cnt    <= 0;
      model_err    <= 1'b0;
      fifo_rd_data <= '0;
    end else begin
      model_err <= mem_rd_en && (model_cnt == 0);
      if (mem_rd_en && model_cnt != 0) begin
        fifo_rd_data <= model_mem[model_rp];
        model_rp     <= (model_rp + 1) % FIFO_DEPTH;
      end
      if (mem_wr_en && (model_cnt < FIFO_DEPTH || mem_rd_en)) begin
        model_mem[model_wp] <= wr_data;
        model_wp            <= (model_wp + 1) % FIFO_DEPTH;
      end
      model_cnt <= model_cnt
                   + ((mem_wr_en && (model_cnt < FIFO_DEPTH || mem_rd_en)) ? 1 : 0)
                   - ((mem_rd_en && model_cnt != 0) ? 1 : 0);
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One cycle: drive inputs at the falling edge, then log strobes and transfers.
  task automatic applyStimulus(input logic wr, input logic [31:0] data, input logic rdy);
    @(negedge CLK);
    mem_wr_en = wr;
    wr_data   = data;
    out_ready = rdy;
    #1;
    cyc++;
    if (mem_rd_en) begin
      rd_pulses++;
      if (mem_count == '0) bad_reads++;
    end
    if (nRST && out_valid && out_ready) begin
      rxq.push_back(out_data);
      if (rxq.size() == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
  endtask

  task automatic drainWords(input int n, input int budget);
    int k = 0;
    while (rxq.size() < n && k < budget) begin
      applyStimulus(1'b0, '0, 1'b1);
      k++;
    end
  endtask

  initial begin
    // Reset values
    #12;
    checkOutput("rst_count", 32'(mem_count), 32'd0);
    checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", out_data, 32'd0);
    checkOutput("rst_uflow", 32'(underflow_err), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // T1: single word, 2-cycle strobe-to-valid latency
    rxq.delete();
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b1);
    checkOutput("t1_rd_idle", 32'(mem_rd_en), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_count1", 32'(mem_count), 32'd1);
    checkOutput("t1_strobe", 32'(mem_rd_en), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_count0", 32'(mem_count), 32'd0);
    checkOutput("t1_no_strobe", 32'(mem_rd_en), 32'd0);
    checkOutput("t1_not_yet", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_data", out_data, 32'hA5A5_0001);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_valid_gone", 32'(out_valid), 32'd0);
    checkOutput("t1_words", 32'(rxq.size()), 32'd1);

    // T2: 32 back-to-back words, one per cycle
    rxq.delete();
    rd_pulses = 0;
    bad_reads = 0;
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 32'(i), 1'b1);
    drainWords(32, 100);
    checkOutput("t2_words", 32'(rxq.size()), 32'd32);
    for (int i = 0; i < 32; i++)
      checkOutput("t2_order", (rxq.size() > i) ? rxq[i] : 32'hDEAD_BEEF, 32'(i));
    checkOutput("t2_streak", 32'(last_cyc - first_cyc), 32'd31);
    checkOutput("t2_reads", 32'(rd_pulses), 32'd32);
    checkOutput("t2_count", 32'(mem_count), 32'd0);

    // T3: consumer stalled, only the queue credit's worth of reads
    rxq.delete();
    rd_pulses = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t3_reads", 32'(rd_pulses), 32'd3);
    checkOutput("t3_count", 32'(mem_count), 32'd7);
    checkOutput("t3_valid", 32'(out_valid), 32'd1);
    checkOutput("t3_head", out_data, 32'h100);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t3_hold", out_data, 32'h100);
    drainWords(10, 60);
    checkOutput("t3_words", 32'(rxq.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      checkOutput("t3_order", (rxq.size() > i) ? rxq[i] : 32'hDEAD_BEEF, 32'h100 + 32'(i));
    checkOutput("t3_count_end", 32'(mem_count), 32'd0);

    // T4: count saturates at FIFO_DEPTH (3 words already moved to the queue)
    rxq.delete();
    rd_pulses = 0;
    for (int i = 0; i < 34; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0);
    applyStimulus(1'b1, 32'h222, 1'b0);
    checkOutput("t4_count31", 32'(mem_count), 32'd31);
    applyStimulus(1'b1, 32'h223, 1'b0);
    checkOutput("t4_count32", 32'(mem_count), 32'd32);
    checkOutput("t4_no_read", 32'(mem_rd_en), 32'd0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t4_saturate", 32'(mem_count), 32'd32);
    checkOutput("t4_reads", 32'(rd_pulses), 32'd3);
    drainWords(35, 120);
    checkOutput("t4_words", 32'(rxq.size()), 32'd35);
    checkOutput("t4_first", (rxq.size() > 0) ? rxq[0] : 32'hDEAD_BEEF, 32'h200);
    checkOutput("t4_last", (rxq.size() > 34) ? rxq[34] : 32'hDEAD_BEEF, 32'h222);
    checkOutput("t4_count_end", 32'(mem_count), 32'd0);

    // T5: write and read in the same cycle at count 1
    rxq.delete();
    applyStimulus(1'b1, 32'h300, 1'b1);
    applyStimulus(1'b1, 32'h301, 1'b1);
    checkOutput("t5_count_pre", 32'(mem_count), 32'd1);
    checkOutput("t5_strobe", 32'(mem_rd_en), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t5_count_hold", 32'(mem_count), 32'd1);
    drainWords(2, 20);
    checkOutput("t5_second", (rxq.size() > 1) ? rxq[1] : 32'hDEAD_BEEF, 32'h301);
    checkOutput("t5_empty_reads", 32'(bad_reads), 32'd0);

    // T6: sticky underflow flag and clear priority
    checkOutput("t6_clean", 32'(underflow_err), 32'd0);
    force_err = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    force_err = 1'b0;
    checkOutput("t6_set", 32'(underflow_err), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t6_sticky", 32'(underflow_err), 32'd1);
    clr_err   = 1'b1;
    force_err = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    clr_err   = 1'b0;
    force_err = 1'b0;
    checkOutput("t6_clear_wins", 32'(underflow_err), 32'd0);

    // T7: asynchronous reset in the middle of a stream
    rxq.delete();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h400 + 32'(i), 1'b1);
    checkOutput("t7_busy", 32'(out_valid), 32'd1);
    #2;
    nRST      = 1'b0;
    mem_wr_en = 1'b0;
    #1;
    checkOutput("t7_count", 32'(mem_count), 32'd0);
    checkOutput("t7_rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("t7_valid", 32'(out_valid), 32'd0);
    checkOutput("t7_data", out_data, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    rxq.delete();
    applyStimulus(1'b1, 32'h1234, 1'b1);
    drainWords(1, 20);
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t7_first", (rxq.size() > 0) ? rxq[0] : 32'hDEAD_BEEF, 32'h1234);
    checkOutput("t7_words", 32'(rxq.size()), 32'd1);
    checkOutput("t7_count_end", 32'(mem_count), 32'd0);
    checkOutput("no_empty_read", 32'(bad_reads), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
